ttt_game_ctrl: RTL and testbench

Turn sequencer and board owner for the tic-tac-toe datapath. It accepts move requests from the player-input front end and enforces legality and alternating turns. It holds the 9-cell board that drives the display and detection logic, detects win and draw, and reports game-over state to the top level.

---
 rtl/ttt_pkg.sv | 40 ++++
 rtl/ttt_win_detect.sv | 44 ++++
 rtl/ttt_game_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared cell codes, controller state encoding and the winning-line
// table for the tic-tac-toe datapath.
//   CELL_*       2-bit cell codes (00 empty, 01 X, 10 O)
//   state_t      controller states PLAY / CHECK / DONE
//   LINE_TBL     8 winning lines as triples of 0-based cell indices
//   other_player returns the opponent's code
package ttt_pkg;

    localparam int unsigned CELL_W  = 2;
    localparam int unsigned N_CELLS = 9;
    localparam int unsigned N_LINES = 8;
    localparam int unsigned BOARD_W = CELL_W * N_CELLS;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Rows 0-2, columns 3-5, main diagonal 6, anti diagonal 7.
    localparam int unsigned LINE_TBL [N_LINES][3] = '{
        '{0, 1, 2},
        '{3, 4, 5},
        '{6, 7, 8},
        '{0, 3, 6},
        '{1, 4, 7},
        '{2, 5, 8},
        '{0, 4, 8},
        '{2, 4, 6}
    };

    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == CELL_X) ? CELL_O : CELL_X;
    endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// ttt_win_detect: combinational win/draw evaluation over the 9-cell board.
//   i_cells    flattened board, cell k (0-based) at bits [2k+1:2k]
//   o_win      some line holds three identical non-empty cells
//   o_winner   code of the winning player (00 when no win)
//   o_line     lowest matching line index (0 when no win)
//   o_full     every cell is non-empty
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] i_cells,
    output logic               o_win,
    output logic [1:0]         o_winner,
    output logic [2:0]         o_line,
    output logic               o_full
);

    // Board-full flag.
    always_comb begin
        o_full = 1'b1;
        for (int unsigned i = 0; i < N_CELLS; i++) begin
            if (i_cells[CELL_W*i +: CELL_W] == CELL_EMPTY) begin
                o_full = 1'b0;
            end
        end
    end

    // Scan lines in index order; the first match wins so the lowest index is reported.
    always_comb begin
        o_win    = 1'b0;
        o_winner = CELL_EMPTY;
        o_line   = 3'd0;
        for (int unsigned l = 0; l < N_LINES; l++) begin
            if (!o_win
                && (i_cells[CELL_W*LINE_TBL[l][0] +: CELL_W] != CELL_EMPTY)
                && (i_cells[CELL_W*LINE_TBL[l][0] +: CELL_W] == i_cells[CELL_W*LINE_TBL[l][1] +: CELL_W])
                && (i_cells[CELL_W*LINE_TBL[l][1] +: CELL_W] == i_cells[CELL_W*LINE_TBL[l][2] +: CELL_W])) begin
                o_win    = 1'b1;
                o_winner = i_cells[CELL_W*LINE_TBL[l][0] +: CELL_W];
                o_line   = 3'(l);
            end
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: turn sequencer and board owner for tic-tac-toe.
//   clk, reset_n            clock, async active-low reset
//   new_game                pulse: clear board and start a new game
//   move_valid, move_pos    move request (cell 1..9 row-major)
//   move_ready              high only in PLAY
//   move_ack, move_err      1-cycle pulses: move written / move rejected
//   pos1..pos9              cell states
//   turn, move_count        player to move, moves written this game
//   game_over, winner,      result, valid while game_over
//   win_line
// All outputs are registered.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter logic [1:0] FIRST_PLAYER = 2'b01,
    parameter bit         ALT_START    = 1'b0
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    output logic       move_ack,
    output logic       move_err,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic [1:0] turn,
    output logic [3:0] move_count,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] win_line
);

    logic [1:0]         r_cells [N_CELLS];
    state_t             r_state;
    logic [1:0]         r_turn;
    logic [1:0]         r_start;
    logic [3:0]         r_count;
    logic               r_ready;
    logic               r_ack;
    logic               r_err;
    logic               r_over;
    logic [1:0]         r_winner;
    logic [2:0]         r_line;

    logic [BOARD_W-1:0] w_cells;
    logic               w_win;
    logic [1:0]         w_win_code;
    logic [2:0]         w_win_line;
    logic               w_full;
    logic [3:0]         w_idx;
    logic               w_pos_ok;
    logic [1:0]         w_target;
    logic               w_legal;
    logic [1:0]         w_next_start;

    // Flatten the board for the detector.
    always_comb begin
        w_cells = '0;
        for (int unsigned i = 0; i < N_CELLS; i++) begin
            w_cells[CELL_W*i +: CELL_W] = r_cells[i];
        end
    end

    ttt_win_detect u_win_detect (
        .i_cells  (w_cells),
        .o_win    (w_win),
        .o_winner (w_win_code),
        .o_line   (w_win_line),
        .o_full   (w_full)
    );

    // Move legality: index in range and target cell empty.
    assign w_idx    = move_pos - 4'd1;
    assign w_pos_ok = (move_pos >= 4'd1) && (move_pos <= 4'd9);

    always_comb begin
        w_target = CELL_EMPTY;
        for (int unsigned i = 0; i < N_CELLS; i++) begin
            if (w_idx == 4'(i)) begin
                w_target = r_cells[i];
            end
        end
    end

    assign w_legal      = w_pos_ok && (w_target == CELL_EMPTY);
    assign w_next_start = ALT_START ? other_player(r_start) : FIRST_PLAYER;

    // Game FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_CELLS; i++) begin
                r_cells[i] <= CELL_EMPTY;
            end
            r_state  <= ST_PLAY;
            r_turn   <= FIRST_PLAYER;
            r_start  <= FIRST_PLAYER;
            r_count  <= 4'd0;
            r_ready  <= 1'b1;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_over   <= 1'b0;
            r_winner <= CELL_EMPTY;
            r_line   <= 3'd0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (new_game) begin
                // New game overrides any move presented in the same cycle.
                for (int unsigned i = 0; i < N_CELLS; i++) begin
                    r_cells[i] <= CELL_EMPTY;
                end
                r_state  <= ST_PLAY;
                r_start  <= w_next_start;
                r_turn   <= w_next_start;
                r_count  <= 4'd0;
                r_ready  <= 1'b1;
                r_over   <= 1'b0;
                r_winner <= CELL_EMPTY;
                r_line   <= 3'd0;
            end else begin
                case (r_state)
                    ST_PLAY: begin
                        if (move_valid) begin
                            if (w_legal) begin
                                for (int unsigned i = 0; i < N_CELLS; i++) begin
                                    if (w_idx == 4'(i)) begin
                                        r_cells[i] <= r_turn;
                                    end
                                end
                                r_count <= r_count + 4'd1;
                                r_ack   <= 1'b1;
                                r_ready <= 1'b0;
                                r_state <= ST_CHECK;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    ST_CHECK: begin
                        // Win is tested before full so a 9th-move win is not a draw.
                        if (w_win) begin
                            r_over   <= 1'b1;
                            r_winner <= w_win_code;
                            r_line   <= w_win_line;
                            r_state  <= ST_DONE;
                        end else if (w_full) begin
                            r_over   <= 1'b1;
                            r_winner <= CELL_EMPTY;
                            r_line   <= 3'd0;
                            r_state  <= ST_DONE;
                        end else begin
                            r_turn  <= other_player(r_turn);
                            r_ready <= 1'b1;
                            r_state <= ST_PLAY;
                        end
                    end
                    ST_DONE: begin
                    end
                    default: begin
                        r_ready <= 1'b1;
                        r_state <= ST_PLAY;
                    end
                endcase
            end
        end
    end

    // Nine moves without a win can only mean a full board.
    a_nine_is_draw: assert property (@(posedge clk) disable iff (!reset_n)
        ((r_state == ST_CHECK) && (r_count == 4'd9) && !w_win) |-> w_full);

    assign move_ready = r_ready;
    assign move_ack   = r_ack;
    assign move_err   = r_err;
    assign pos1       = r_cells[0];
    assign pos2       = r_cells[1];
    assign pos3       = r_cells[2];
    assign pos4       = r_cells[3];
    assign pos5       = r_cells[4];
    assign pos6       = r_cells[5];
    assign pos7       = r_cells[6];
    assign pos8       = r_cells[7];
    assign pos9       = r_cells[8];
    assign turn       = r_turn;
    assign move_count = r_count;
    assign game_over  = r_over;
    assign winner     = r_winner;
    assign win_line   = r_line;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Two instances share stimulus: u0 with ALT_START=0, u1 with ALT_START=1,
// both FIRST_PLAYER=X, each checked against a per-instance game model.
module tb_ttt_game_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       new_game;
    logic       move_valid;
    logic [3:0] move_pos;

    logic [1:0] d_pos    [2][9];
    logic [1:0] d_turn   [2];
    logic [3:0] d_cnt    [2];
    logic       d_ready  [2];
    logic       d_ack    [2];
    logic       d_err    [2];
    logic       d_over   [2];
    logic [1:0] d_winner [2];
    logic [2:0] d_line   [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ttt_game_ctrl #(
            .FIRST_PLAYER (2'b01),
            .ALT_START    (g == 1)
        ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .new_game   (new_game),
            .move_valid (move_valid),
            .move_pos   (move_pos),
            .move_ready (d_ready[g]),
            .move_ack   (d_ack[g]),
            .move_err   (d_err[g]),
            .pos1       (d_pos[g][0]),
            .pos2       (d_pos[g][1]),
            .pos3       (d_pos[g][2]),
            .pos4       (d_pos[g][3]),
            .pos5       (d_pos[g][4]),
            .pos6       (d_pos[g][5]),
            .pos7       (d_pos[g][6]),
            .pos8       (d_pos[g][7]),
            .pos9       (d_pos[g][8]),
            .turn       (d_turn[g]),
            .move_count (d_cnt[g]),
            .game_over  (d_over[g]),
            .winner     (d_winner[g]),
            .win_line   (d_line[g])
        );
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 = accepting moves, 1 = evaluating, 2 = finished.
    int m_cell  [2][9];
    int m_turn  [2];
    int m_start [2];
    int m_cnt   [2];
    int m_phase [2];
    int m_over  [2];
    int m_win   [2];
    int m_line  [2];
    int m_ack   [2];
    int m_err   [2];

    function automatic int line_cell(input int l, input int k);
        if (l < 3) return 3 * l + k;
        if (l < 6) return (l - 3) + 3 * k;
        if (l == 6) return 4 * k;
        return 2 + 2 * k;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 9; i++) m_cell[g][i] = 0;
            m_turn[g]  = 1;
            m_start[g] = 1;
            m_cnt[g]   = 0;
            m_phase[g] = 0;
            m_over[g]  = 0;
            m_win[g]   = 0;
            m_line[g]  = 0;
            m_ack[g]   = 0;
            m_err[g]   = 0;
        end
    endtask

    task automatic model_step(input bit ng, input bit v, input int pos);
        int wl;
        int filled;
        int a;
        for (int g = 0; g < 2; g++) begin
            m_ack[g] = 0;
            m_err[g] = 0;
            if (ng) begin
                for (int i = 0; i < 9; i++) m_cell[g][i] = 0;
                m_cnt[g]   = 0;
                m_over[g]  = 0;
                m_win[g]   = 0;
                m_line[g]  = 0;
                m_phase[g] = 0;
                if (g == 1) m_start[g] = 3 - m_start[g];
                m_turn[g] = m_start[g];
            end else if (m_phase[g] == 0) begin
                if (v) begin
                    if (pos >= 1 && pos <= 9 && m_cell[g][pos-1] == 0) begin
                        m_cell[g][pos-1] = m_turn[g];
                        m_cnt[g]++;
                        m_ack[g]   = 1;
                        m_phase[g] = 1;
                    end else begin
                        m_err[g] = 1;
                    end
                end
            end else if (m_phase[g] == 1) begin
                wl = -1;
                for (int l = 0; l < 8; l++) begin
                    a = m_cell[g][line_cell(l, 0)];
                    if (wl < 0 && a != 0 && a == m_cell[g][line_cell(l, 1)]
                        && a == m_cell[g][line_cell(l, 2)]) wl = l;
                end
                filled = 0;
                for (int i = 0; i < 9; i++) if (m_cell[g][i] != 0) filled++;
                if (wl >= 0) begin
                    m_over[g]  = 1;
                    m_win[g]   = m_cell[g][line_cell(wl, 0)];
                    m_line[g]  = wl;
                    m_phase[g] = 2;
                end else if (filled == 9) begin
                    m_over[g]  = 1;
                    m_win[g]   = 0;
                    m_line[g]  = 0;
                    m_phase[g] = 2;
                end else begin
                    m_turn[g]  = 3 - m_turn[g];
                    m_phase[g] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] gb;
        logic [31:0] eb;
        for (int g = 0; g < 2; g++) begin
            gb = '0;
            eb = '0;
            for (int i = 0; i < 9; i++) begin
                gb[2*i +: 2] = d_pos[g][i];
                eb[2*i +: 2] = 2'(m_cell[g][i]);
            end
            chk($sformatf("u%0d.board", g), gb, eb);
            chk($sformatf("u%0d.turn", g), 32'(d_turn[g]), 32'(m_turn[g]));
            chk($sformatf("u%0d.count", g), 32'(d_cnt[g]), 32'(m_cnt[g]));
            chk($sformatf("u%0d.ready", g), 32'(d_ready[g]), 32'(m_phase[g] == 0));
            chk($sformatf("u%0d.ack", g), 32'(d_ack[g]), 32'(m_ack[g]));
            chk($sformatf("u%0d.err", g), 32'(d_err[g]), 32'(m_err[g]));
            chk($sformatf("u%0d.over", g), 32'(d_over[g]), 32'(m_over[g]));
            chk($sformatf("u%0d.winner", g), 32'(d_winner[g]), 32'(m_win[g]));
            chk($sformatf("u%0d.line", g), 32'(d_line[g]), 32'(m_line[g]));
        end
    endtask

    // Entered and left at a falling edge.
    task automatic do_cycle(input bit ng, input bit v, input logic [3:0] pos);
        new_game   = ng;
        move_valid = v;
        move_pos   = pos;
        @(posedge clk);
        #1;
        model_step(ng, v, int'(pos));
        compare_all();
        @(negedge clk);
    endtask

    task automatic play(input logic [3:0] pos);
        do_cycle(1'b0, 1'b1, pos);
        do_cycle(1'b0, 1'b0, 4'd0);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_pos   = 4'd0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int r;
        bit ng;
        bit v;
        logic [3:0] p;

        reset_n    = 1'b0;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_pos   = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        chk("rst.turn", 32'(d_turn[0]), 32'd1);
        chk("rst.ready", 32'(d_ready[0]), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // X wins on the top row.
        play(4'd1); play(4'd4); play(4'd2); play(4'd5); play(4'd3);
        chk("win.over", 32'(d_over[0]), 32'd1);
        chk("win.winner", 32'(d_winner[0]), 32'd1);
        chk("win.line", 32'(d_line[0]), 32'd0);
        chk("win.count", 32'(d_cnt[0]), 32'd5);

        // Requests in DONE are ignored.
        repeat (4) do_cycle(1'b0, 1'b1, 4'd7);
        chk("done.pos7", 32'(d_pos[0][6]), 32'd0);
        chk("done.ack", 32'(d_ack[0]), 32'd0);

        // new_game beats a simultaneous legal move.
        do_cycle(1'b1, 1'b1, 4'd5);
        chk("ng.ack", 32'(d_ack[0]), 32'd0);
        chk("ng.pos5", 32'(d_pos[0][4]), 32'd0);
        chk("ng.turn_fixed", 32'(d_turn[0]), 32'd1);
        chk("ng.turn_alt2", 32'(d_turn[1]), 32'd2);

        // Draw, with move_valid held high through one CHECK.
        do_cycle(1'b0, 1'b1, 4'd1);
        do_cycle(1'b0, 1'b1, 4'd2);
        play(4'd2); play(4'd3); play(4'd5); play(4'd4);
        play(4'd6); play(4'd8); play(4'd7); play(4'd9);
        chk("draw.over", 32'(d_over[0]), 32'd1);
        chk("draw.winner", 32'(d_winner[0]), 32'd0);
        chk("draw.count", 32'(d_cnt[0]), 32'd9);

        do_cycle(1'b1, 1'b0, 4'd0);
        chk("ng.turn_alt3", 32'(d_turn[1]), 32'd1);

        // Illegal requests: occupied, zero, out of range.
        play(4'd5);
        do_cycle(1'b0, 1'b1, 4'd5);
        do_cycle(1'b0, 1'b1, 4'd0);
        do_cycle(1'b0, 1'b1, 4'd12);
        chk("ill.turn", 32'(d_turn[0]), 32'd2);
        chk("ill.count", 32'(d_cnt[0]), 32'd1);
        chk("ill.pos5", 32'(d_pos[0][4]), 32'd1);

        // Reset while in CHECK.
        do_cycle(1'b0, 1'b1, 4'd1);
        async_reset();
        chk("midrst.count", 32'(d_cnt[0]), 32'd0);
        play(4'd2);
        chk("midrst.first", 32'(d_pos[0][1]), 32'd1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 199));
            if (r < 2) begin
                async_reset();
            end else begin
                ng = (r < 6);
                v  = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 7) == 0) p = 4'($urandom_range(0, 15));
                else                           p = 4'($urandom_range(1, 9));
                do_cycle(ng, v, p);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
